// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use and mult/div stalls, exception
// entry (int_req) and eret return (clr_delay) with EXL tracking.
module pipe_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_use_rs,
  input  logic       d_use_rt,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic       e_is_load,
  input  logic [4:0] e_rd,
  input  logic       d_is_md,
  input  logic       md_start,
  input  logic       md_is_div,
  input  logic       exc_req,
  input  logic       d_is_eret,
  output logic       stall,
  output logic       int_req,
  output logic       clr_delay,
  output logic       md_busy,
  output logic       in_handler
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned REG_W = 5;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HANDLER = 1'b1
  } state_e;

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   md_cnt_q;
  logic [CNT_W-1:0]   md_cnt_d;
  logic               md_busy_q;
  logic               md_busy_d;
  logic               lu_c;
  logic               in_run_c;
  logic               md_load_c;

  // Hazard detection, control outputs, FSM next state and md counter update
  always_comb begin
    state_d   = state_q;
    md_cnt_d  = md_cnt_q;
    md_busy_d = md_busy_q;
    int_req   = 1'b0;
    stall     = 1'b0;
    clr_delay = 1'b0;
    lu_c      = 1'b0;
    md_load_c = 1'b0;
    in_run_c  = (state_q == ST_RUN);

    // Load-use: $zero never carries a real dependency
    lu_c = e_is_load && (e_rd != REG_W'(0)) &&
           ((d_use_rs && (d_rs == e_rd)) || (d_use_rt && (d_rt == e_rd)));

    // Outputs forced low while reset is held so nothing leaks out mid-reset
    int_req   = !reset && exc_req && in_run_c;
    stall     = !reset && !int_req && (lu_c || (d_is_md && md_busy_q));
    clr_delay = !reset && d_is_eret && !in_run_c && !stall && !int_req;

    if (int_req) begin
      state_d = ST_HANDLER;
    end else if (clr_delay) begin
      state_d = ST_RUN;
    end

    // A flushed issuing instruction must not start the unit
    md_load_c = md_start && !md_busy_q && !int_req;
    if (md_load_c) begin
      md_cnt_d = md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (md_cnt_q != CNT_W'(0)) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end
    md_busy_d = (md_cnt_d != CNT_W'(0));
  end

  // State, counter and busy flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      md_cnt_q  <= CNT_W'(0);
      md_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      md_cnt_q  <= md_cnt_d;
      md_busy_q <= md_busy_d;
    end
  end

  assign md_busy    = md_busy_q;
  assign in_handler = (state_q == ST_HANDLER);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

  logic       clk;
  logic       reset;
  logic       d_use_rs, d_use_rt;
  logic [4:0] d_rs, d_rt, e_rd;
  logic       e_is_load, d_is_md, md_start, md_is_div, exc_req, d_is_eret;
  logic       stall, int_req, clr_delay, md_busy, in_handler;

  int n_cmp;
  int n_err;

  // Reference model state
  bit m_handler;
  int m_md_left;

  pipe_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_rs(d_rs), .d_rt(d_rt),
    .e_is_load(e_is_load), .e_rd(e_rd), .d_is_md(d_is_md),
    .md_start(md_start), .md_is_div(md_is_div), .exc_req(exc_req),
    .d_is_eret(d_is_eret), .stall(stall), .int_req(int_req),
    .clr_delay(clr_delay), .md_busy(md_busy), .in_handler(in_handler)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    d_use_rs = 0; d_use_rt = 0; d_rs = 0; d_rt = 0;
    e_is_load = 0; e_rd = 0; d_is_md = 0; md_start = 0;
    md_is_div = 0; exc_req = 0; d_is_eret = 0;
  endtask

  task automatic model_reset();
    m_handler = 0;
    m_md_left = 0;
  endtask

  // Inputs were applied at negedge; settle, compare everything, advance model
  task automatic check_cycle();
    bit e_int, e_lu, e_stall, e_clr;
    #1;
    e_int   = exc_req && !m_handler;
    e_lu    = e_is_load && (e_rd != 0) &&
              ((d_use_rs && d_rs == e_rd) || (d_use_rt && d_rt == e_rd));
    e_stall = !e_int && (e_lu || (d_is_md && m_md_left > 0));
    e_clr   = d_is_eret && m_handler && !e_stall && !e_int;
    check("int_req",    int_req,    e_int);
    check("stall",      stall,      e_stall);
    check("clr_delay",  clr_delay,  e_clr);
    check("md_busy",    md_busy,    m_md_left > 0);
    check("in_handler", in_handler, m_handler);
    if (e_int) m_handler = 1;
    else if (e_clr) m_handler = 0;
    if (md_start && m_md_left == 0 && !e_int) m_md_left = md_is_div ? 10 : 5;
    else if (m_md_left > 0) m_md_left--;
  endtask

  task automatic run_md(input bit is_div, input int exp_cycles, input string tag);
    int busy_cnt, stall_cnt;
    busy_cnt = 0; stall_cnt = 0;
    @(negedge clk); clear_inputs(); md_start = 1; md_is_div = is_div;
    check_cycle();
    for (int i = 0; i < exp_cycles + 3; i++) begin
      @(negedge clk); clear_inputs(); d_is_md = 1;
      check_cycle();
      if (md_busy) busy_cnt++;
      if (stall) stall_cnt++;
    end
    check({tag, "_busy_cycles"}, busy_cnt, exp_cycles);
    check({tag, "_stall_cycles"}, stall_cnt, exp_cycles);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    clear_inputs();
    model_reset();

    // Reset held for three cycles
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 0;
    #1;
    check("rst_stall", stall, 0);
    check("rst_int_req", int_req, 0);
    check("rst_clr_delay", clr_delay, 0);
    check("rst_md_busy", md_busy, 0);
    check("rst_in_handler", in_handler, 0);

    // Load-use hazard, then same pattern on $zero
    @(negedge clk); clear_inputs();
    e_is_load = 1; e_rd = 8; d_use_rs = 1; d_rs = 8;
    check_cycle();
    check("lu_stall_rs", stall, 1);
    @(negedge clk); e_rd = 0; d_rs = 0;
    check_cycle();
    check("lu_zero_nostall", stall, 0);
    @(negedge clk); clear_inputs();
    e_is_load = 1; e_rd = 17; d_use_rt = 1; d_rt = 17; d_rs = 17;
    check_cycle();
    check("lu_stall_rt", stall, 1);

    // Divide then multiply busy windows
    run_md(1, 10, "div");
    run_md(0, 5, "mult");

    // Exception entry; second request inside the handler is ignored
    @(negedge clk); clear_inputs(); exc_req = 1;
    check_cycle();
    check("exc_int_req", int_req, 1);
    @(negedge clk); clear_inputs();
    check_cycle();
    check("exc_int_once", int_req, 0);
    check("exc_in_handler", in_handler, 1);
    @(negedge clk); clear_inputs();
    check_cycle();
    @(negedge clk); clear_inputs(); exc_req = 1;
    check_cycle();
    check("exc_nested_ignored", int_req, 0);

    // eret blocked by load-use, then released
    @(negedge clk); clear_inputs();
    d_is_eret = 1; e_is_load = 1; e_rd = 3; d_use_rs = 1; d_rs = 3;
    check_cycle();
    check("eret_stalled", clr_delay, 0);
    @(negedge clk); e_is_load = 0;
    check_cycle();
    check("eret_clr", clr_delay, 1);
    @(negedge clk); clear_inputs();
    check_cycle();
    check("eret_left_handler", in_handler, 0);

    // eret outside the handler is a nop
    @(negedge clk); clear_inputs(); d_is_eret = 1;
    check_cycle();
    check("eret_run_nop", clr_delay, 0);

    // Exception and md_start together: issue is dropped
    @(negedge clk); clear_inputs(); exc_req = 1; md_start = 1; md_is_div = 1;
    check_cycle();
    check("exc_md_int", int_req, 1);
    @(negedge clk); clear_inputs();
    check_cycle();
    check("exc_md_nobusy", md_busy, 0);
    // Leave the handler via eret
    @(negedge clk); clear_inputs(); d_is_eret = 1;
    check_cycle();

    // Asynchronous reset mid-divide
    @(negedge clk); clear_inputs(); md_start = 1; md_is_div = 1;
    check_cycle();
    repeat (3) begin
      @(negedge clk); clear_inputs();
      check_cycle();
    end
    check("div_running", md_busy, 1);
    @(negedge clk); clear_inputs(); reset = 1;
    #1;
    check("async_rst_busy", md_busy, 0);
    check("async_rst_handler", in_handler, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk); reset = 0;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      d_use_rs  = 1'($urandom_range(0, 1));
      d_use_rt  = 1'($urandom_range(0, 1));
      d_rs      = 5'($urandom_range(0, 3));
      d_rt      = 5'($urandom_range(0, 3));
      e_rd      = 5'($urandom_range(0, 3));
      e_is_load = ($urandom_range(0, 3) == 0);
      d_is_md   = 1'($urandom_range(0, 1));
      md_start  = ($urandom_range(0, 3) == 0);
      md_is_div = 1'($urandom_range(0, 1));
      exc_req   = ($urandom_range(0, 15) == 0);
      d_is_eret = ($urandom_range(0, 3) == 0);
      check_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
